arb_4_req_v: RTL and testbench
==============================

ARB_4_REQ_V -- requirements
Module: arb_4_req_v

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles per ownership (legal 1..255).
REQ-002 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_req  input  4  request lines; bit n = requester n; level-sensitive.
REQ-005 Port: o_grant  output  4  one-hot grant, registered; all-zero when no owner.
REQ-006 Port: o_code  output  2  binary index of current owner, registered; 2'b00 when no owner.
REQ-007 Port: o_valid  output  1  high while any grant is active, registered.
REQ-008 Port: o_timeout  output  1  one-cycle pulse when an ownership is revoked by the hold limit.

Function
REQ-009 Two states SHALL exist: IDLE (no owner) and GRANT (one owner).
REQ-010 In IDLE, a rising edge with i_req != 0 SHALL enter GRANT with the selected winner; one-cycle latency from request to o_grant.
REQ-011 Winner selection (default build) SHALL be fixed priority: lowest-index asserted request wins, bit 0 highest.
REQ-012 In GRANT, the owner SHALL keep the grant while its i_req bit stays high and its hold count is below MAX_HOLD.
REQ-013 Owner dropping i_req SHALL cause, at that edge, selection among remaining requests (owner excluded); none pending -> IDLE, all outputs zero next cycle; no idle bubble between owners.
REQ-014 Hold counter SHALL load 1 on every new grant and increment each cycle the same owner holds; width ceil(log2(MAX_HOLD+1)).
REQ-015 Counter reaching MAX_HOLD with owner still requesting SHALL force re-selection excluding the owner and assert o_timeout for exactly the next cycle.
REQ-016 On timeout with no other request pending, the owner SHALL retain the grant, counter reloads 1, o_timeout still pulses.
REQ-017 o_grant, o_code and o_valid SHALL always be mutually consistent; o_grant never has more than one bit set.
REQ-018 Requests arriving for non-owners during GRANT SHALL NOT preempt the owner.
REQ-019 MAX_HOLD=1 SHALL re-arbitrate every cycle while others request.

Reset
REQ-020 i_rst high SHALL immediately (asynchronously) force IDLE, o_grant=0, o_code=0, o_valid=0, o_timeout=0, counter=0, last-owner pointer=3.
REQ-021 Reset mid-grant SHALL drop the grant without waiting for a clock edge; first edge after release behaves as from IDLE.

Configuration
REQ-022 Macro ARB_ROUND_ROBIN_EN defined: selection SHALL start search at (last owner + 1) mod 4, wrapping circularly; last-owner pointer updates on every new grant.
REQ-023 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-011; pointer logic absent; all other behaviour identical.

Verification
REQ-024 Reset, i_req=4'b0110 -> one edge later o_grant=4'b0010, o_code=01, o_valid=1.
REQ-025 Owner 1 holds, i_req 4'b0110 -> 4'b0100 -> next cycle o_grant=4'b0100, o_code=10, no zero cycle between.
REQ-026 MAX_HOLD=4, i_req=4'b1001 held -> owner 0 for 4 cycles, then o_grant=4'b1000, o_timeout=1 for one cycle.
REQ-027 MAX_HOLD=4, i_req=4'b0001 held -> grant stays 4'b0001, o_timeout pulses every 4 cycles.
REQ-028 ARB_ROUND_ROBIN_EN, MAX_HOLD=1, i_req=4'b1111 -> o_code sequence 00,01,10,11,00; undefined -> o_code 00,01,00,01 (exclusion only).
REQ-029 i_rst asserted mid-cycle during grant -> o_grant=0, o_valid=0 before next clock edge.

Source files
------------

// File: rtl/arb_4_req_v.sv
// Four-requester arbiter with a per-ownership hold limit and a timeout pulse.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority (bit 0 highest) otherwise.
module arb_4_req_v #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant,
  output logic [1:0] o_code,
  output logic       o_valid,
  output logic       o_timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       code_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic [3:0]       others;
  logic             owner_req;
  logic             at_max;
  logic [1:0]       start;
  logic [1:0]       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last, last_nxt;
  assign start = last + 2'd1;
`else
  assign start = 2'd0;
`endif

  // First asserted candidate found when scanning circularly from start.
  function automatic logic [1:0] pick(input logic [3:0] cand, input logic [1:0] first);
    logic [1:0] idx;
    pick = first;
    for (int i = 3; i >= 0; i--) begin
      idx = first + 2'(i);
      if (cand[idx]) pick = idx;
    end
  endfunction

  // In IDLE o_grant is zero, so "others" is simply every request.
  assign others    = i_req & ~o_grant;
  assign owner_req = |(i_req & o_grant);
  assign at_max    = (cnt == CNT_W'(MAX_HOLD));
  assign win       = pick(others, start);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    grant_nxt   = o_grant;
    code_nxt    = o_code;
    valid_nxt   = o_valid;
    timeout_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_nxt    = last;
`endif
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = GRANT;
          cnt_nxt   = CNT_W'(1);
          grant_nxt = 4'b0001 << win;
          code_nxt  = win;
          valid_nxt = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_nxt  = win;
`endif
        end
      end
      GRANT: begin
        if (owner_req && !at_max) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (|others) begin
          // Hand over directly to the next owner; timeout only if the old owner still wanted it.
          cnt_nxt     = CNT_W'(1);
          grant_nxt   = 4'b0001 << win;
          code_nxt    = win;
          timeout_nxt = owner_req;
`ifdef ARB_ROUND_ROBIN_EN
          last_nxt    = win;
`endif
        end else if (owner_req) begin
          cnt_nxt     = CNT_W'(1);
          timeout_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          grant_nxt = 4'b0000;
          code_nxt  = 2'b00;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      o_grant   <= 4'b0000;
      o_code    <= 2'b00;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= 2'd3;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_grant   <= grant_nxt;
      o_code    <= code_nxt;
      o_valid   <= valid_nxt;
      o_timeout <= timeout_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      last      <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_arb_4_req_v.sv
// Scoreboard bench for arb_4_req_v: two instances (MAX_HOLD=4 and MAX_HOLD=1) share one request bus.
module tb_arb_4_req_v;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] code;
    logic       valid;
    logic       timeout;
  } exp_t;

  typedef struct {
    int owner;
    int hold;
    int last;
    int limit;
  } mdl_t;

  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_req;
  logic [3:0] g0, g1;
  logic [1:0] c0, c1;
  logic       v0, v1, t0, t1;

  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   popped = 0;
  mdl_t m [2];
  exp_t q0 [$];
  exp_t q1 [$];

  arb_4_req_v #(.MAX_HOLD(4)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .o_grant(g0), .o_code(c0), .o_valid(v0), .o_timeout(t0)
  );

  arb_4_req_v #(.MAX_HOLD(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .o_grant(g1), .o_code(c1), .o_valid(v1), .o_timeout(t1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic exp_t expect_of(input int k, input logic to);
    exp_t e;
    e.grant   = (m[k].owner >= 0) ? 4'(1 << m[k].owner) : 4'b0000;
    e.code    = (m[k].owner >= 0) ? 2'(m[k].owner) : 2'b00;
    e.valid   = (m[k].owner >= 0);
    e.timeout = to;
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m[k].owner = -1;
      m[k].hold  = 0;
      m[k].last  = 3;
    end
    m[0].limit = 4;
    m[1].limit = 1;
  endtask

  // One clock edge of the arbitration rules, in terms of owner index and hold count.
  task automatic model_step(input int k, input logic [3:0] req, output exp_t e);
    int   o, base, win, c;
    logic keep, to;
    o    = m[k].owner;
    keep = (o >= 0) && req[o];
    to   = 1'b0;
    if (keep && m[k].hold < m[k].limit) begin
      m[k].hold++;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      base = (m[k].last + 1) % 4;
`else
      base = 0;
`endif
      win = -1;
      for (int i = 0; i < 4; i++) begin
        c = (base + i) % 4;
        if (win < 0 && req[c] && c != o) win = c;
      end
      if (win >= 0) begin
        m[k].owner = win;
        m[k].hold  = 1;
        m[k].last  = win;
        to         = keep;
      end else if (keep) begin
        m[k].hold = 1;
        to        = 1'b1;
      end else begin
        m[k].owner = -1;
        m[k].hold  = 0;
      end
    end
    e = expect_of(k, to);
  endtask

  task automatic drive(input logic [3:0] req);
    exp_t e;
    @(negedge i_clk);
    i_req = req;
    model_step(0, req, e);
    q0.push_back(e);
    model_step(1, req, e);
    q1.push_back(e);
    pushed++;
  endtask

  task automatic cmp(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got grant=%b code=%b valid=%b timeout=%b, expected grant=%b code=%b valid=%b timeout=%b",
               name, $time, act.grant, act.code, act.valid, act.timeout,
               exp.grant, exp.code, exp.valid, exp.timeout);
    end
  endtask

  task automatic cmp_consistent(input string name, input exp_t act);
    logic ok;
    ok = $onehot0(act.grant) && (act.valid == (|act.grant)) &&
         (act.valid ? (act.grant == 4'(1 << act.code)) : (act.code == 2'b00));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: inconsistent grant=%b code=%b valid=%b", name, $time,
               act.grant, act.code, act.valid);
    end
  endtask

  // Monitor: after each edge, pop the expected response and compare.
  always begin
    exp_t e;
    @(posedge i_clk);
    #1;
    if (q0.size() > 0 && q1.size() > 0) begin
      e = q0.pop_front();
      cmp("hold4", {g0, c0, v0, t0}, e);
      cmp_consistent("hold4_consistency", {g0, c0, v0, t0});
      e = q1.pop_front();
      cmp("hold1", {g1, c1, v1, t1}, e);
      cmp_consistent("hold1_consistency", {g1, c1, v1, t1});
      popped++;
    end
  end

  initial begin
    logic [3:0] prev;
    exp_t zero;
    zero  = '0;
    i_rst = 1'b1;
    i_req = 4'b0000;
    model_reset();
    repeat (2) @(posedge i_clk);
    #3;
    cmp("reset_hold4", {g0, c0, v0, t0}, zero);
    cmp("reset_hold1", {g1, c1, v1, t1}, zero);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Handover without bubble, then idle.
    drive(4'b0110); drive(4'b0110); drive(4'b0100); drive(4'b0100);
    drive(4'b0000); drive(4'b0000);
    // Hold limit with a competitor, then a lone requester.
    repeat (8)  drive(4'b1001);
    drive(4'b0000);
    repeat (10) drive(4'b0001);
    drive(4'b0000);
    repeat (9)  drive(4'b1111);
    drive(4'b0000);

    // Asynchronous reset in the middle of a grant.
    drive(4'b0010); drive(4'b0010);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    cmp("async_reset_hold4", {g0, c0, v0, t0}, zero);
    cmp("async_reset_hold1", {g1, c1, v1, t1}, zero);
    model_reset();
    i_req = 4'b0000;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(4'b1000); drive(4'b1100); drive(4'b0100);

    // Random traffic; requests mostly persist so hold limits are reached.
    prev = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) prev = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) prev = prev ^ 4'(1 << $urandom_range(0, 3));
      drive(prev);
    end
    drive(4'b0000);
    repeat (3) @(posedge i_clk);
    #2;
    checks++;
    if (popped != pushed || q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: popped %0d, expected %0d", popped, pushed);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
